mac_rr_scheduler: RTL and testbench
===================================

# mac_rr_scheduler

Round-robin scheduler that shares one `pipelined_mul_acc` instance among `NUM_REQ` requesters. Each requester presents an (a, b, c) operand set over a valid/ready handshake. The scheduler issues at most one set per cycle to the MAC and tags every issued set with its requester ID. Because the MAC cannot stall, output back-pressure is handled with credits: tagged results are collected into a response FIFO that the consumer drains through its own valid/ready handshake.

## Interface

**Parameters**
- `NUM_REQ`, default 4: number of requesters, 2..8.
- `FIFO_DEPTH`, default 8: response FIFO entries, power of 2, ≥ `MAC_LAT`.
- `MAC_LAT`, default 4: MAC stages, counting the input capture register.
- `ID_W`, default `$clog2(NUM_REQ)`: requester ID width.

**Ports** (clock and reset first)
- `clk`, in, 1: single clock, rising edge.
- `reset`, in, 1: asynchronous, active-low; the block is held in reset while 0.
- `req_valid`, in, `NUM_REQ`: per-requester operand valid.
- `req_ready`, out, `NUM_REQ`: per-requester accept; one-hot or zero.
- `req_a`, in, `NUM_REQ*8`: packed operand a; requester i uses bits [8i+7:8i].
- `req_b`, in, `NUM_REQ*8`: packed operand b.
- `req_c`, in, `NUM_REQ*16`: packed addend c.
- `mac_a`, out, 8: to MAC `in_a`.
- `mac_b`, out, 8: to MAC `in_b`.
- `mac_c`, out, 16: to MAC `in_c`.
- `mac_valid`, out, 1: to MAC `valid_in`.
- `mac_ready_in`, out, 1: to MAC `ready_in`; tied to 1.
- `mac_result`, in, 16: from MAC `result`.
- `mac_valid_out`, in, 1: from MAC `valid_out`.
- `rsp_valid`, out, 1: response FIFO not empty.
- `rsp_ready`, in, 1: consumer accepts the head entry.
- `rsp_data`, out, 16: result at the FIFO head.
- `rsp_id`, out, `ID_W`: requester ID at the FIFO head.
- `err`, out, 1: sticky tag/result misalignment flag.

## Operation
- **Credit.** `credit_ok = (fifo_count + inflight) < FIFO_DEPTH`. `inflight` is the number of valid stages in the tag pipe.
- **Arbitration.** Arbitration is combinational, round-robin from pointer `rr_ptr`.
  - Grant goes to the first i with `req_valid[i]=1`, searching `rr_ptr+1`, `rr_ptr+2`, … with wrap modulo `NUM_REQ`.
  - A grant is made only if `credit_ok=1`.
  - `req_ready = grant` (one-hot, or 0 when there is no credit or no request).
- **Issue.** `mac_valid = |grant`. `mac_a`/`mac_b`/`mac_c` are muxed from the granted requester. With no grant they are driven to 0.
- **Pointer update.** On issue, `rr_ptr <=` granted index. With no issue, `rr_ptr` holds.
- **Tag pipe.** `MAC_LAT` stages of {valid, id}.
  - Stage 1 loads {`mac_valid`, granted id} every cycle.
  - Stages then shift unconditionally, matching the non-stalling MAC.
- **Retire.** When the last tag stage is valid and `mac_valid_out=1`, {`mac_result`, tag id} is pushed into the FIFO.
- **Overflow.** The credit rule makes FIFO overflow impossible. A push to a full FIFO sets `err`, and the data is dropped.
- **Misalignment.** Last tag stage valid with `mac_valid_out=0`, or `mac_valid_out=1` with no valid tag, sets `err`. In either case nothing is pushed.
- **`err` clearing.** `err` clears only on reset.
- **FIFO.** Circular buffer with wrap-around read and write pointers.
  - Pop on `rsp_valid && rsp_ready`.
  - Simultaneous push and pop is allowed when full or empty. When empty, the pushed entry becomes visible the next cycle; there is no fall-through.
  - `rsp_data`/`rsp_id` hold stable while `rsp_valid=1 && rsp_ready=0`.
- **Arithmetic.** The result is computed by the MAC as a·b + c, mod 2^16. The scheduler never modifies data.

## Timing
- **Reset values** (while `reset=0`):
  - `req_ready=0`, `mac_valid=0`, `mac_a/b/c=0`, `rsp_valid=0`, `rsp_data=0`, `rsp_id=0`, `err=0`.
  - `rr_ptr=NUM_REQ-1`, so requester 0 has first priority.
  - Tag pipe cleared, FIFO empty.
- **Reset mid-operation.** In-flight tags and FIFO contents are discarded. The MAC must be reset over the same window. A MAC result arriving after release with no tag sets `err`.
- **Latency.**
  - A request accepted at edge E0 is pushed at edge E0+`MAC_LAT`.
  - `rsp_valid` rises in the cycle after E0+`MAC_LAT` (4 cycles at default) if the FIFO was empty.
- **Throughput.** One issue per cycle while `credit_ok` holds.
- **Steady stall.** With `rsp_ready=0`, at most `FIFO_DEPTH` issues occur in total; `req_ready` then stays 0.
- **Pop and credit.** A pop at edge E frees a credit for issue in the cycle after E.
- **Fairness.** With all requesters valid, grants rotate 0,1,2,3,0,… with no requester starved.
- **Single requester.** A lone requester is granted every cycle.

## Test plan
1. **Reset.** Hold `reset=0` with all `req_valid=1` → `req_ready=0`, `mac_valid=0`, `rsp_valid=0`, `err=0`. Release; the first grant goes to requester 0.
2. **Single op.** Req1 sends a=3, b=5, c=7 at E0 → `rsp_valid` after E4 with `rsp_data=22`, `rsp_id=1`.
3. **Wrap arithmetic.** a=255, b=255, c=0xFFFF → `rsp_data=0xFE00`.
4. **Fairness.** All 4 requesters valid for 8 cycles with `rsp_ready=1` → ids 0,1,2,3,0,1,2,3 issued back-to-back. Responses return in the same order, one per cycle.
5. **Back-pressure.** `rsp_ready=0` with requesters continuously valid → exactly 8 accepts, then `req_ready=0`. Raise `rsp_ready` → one new accept per pop; no loss, `err=0`.
6. **Misalignment.** Force `mac_valid_out=1` with an empty tag pipe → `err=1` and stays 1; nothing pushed to the FIFO.

Source files
------------

// File: rtl/mac_rr_scheduler.sv
// rtl/mac_rr_scheduler.sv - round-robin sharing of one pipelined MAC with a tag pipe and response FIFO
// Credits cover FIFO occupancy plus in-flight tags, so the non-stalling MAC can never overrun the FIFO.

module mac_rsp_fifo #(
   parameter int DEPTH = 8,
   parameter int W     = 18
)(
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic [W-1:0]             push_data,
   input  logic                     pop,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count,
   output logic [W-1:0]             head
);
   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || pop);
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end
endmodule

module mac_rr_scheduler #(
   parameter int NUM_REQ    = 4,
   parameter int FIFO_DEPTH = 8,
   parameter int MAC_LAT    = 4,
   parameter int ID_W       = $clog2(NUM_REQ)
)(
   input  logic                    clk,
   input  logic                    reset,
   input  logic [NUM_REQ-1:0]      req_valid,
   output logic [NUM_REQ-1:0]      req_ready,
   input  logic [NUM_REQ*8-1:0]    req_a,
   input  logic [NUM_REQ*8-1:0]    req_b,
   input  logic [NUM_REQ*16-1:0]   req_c,
   output logic [7:0]              mac_a,
   output logic [7:0]              mac_b,
   output logic [15:0]             mac_c,
   output logic                    mac_valid,
   output logic                    mac_ready_in,
   input  logic [15:0]             mac_result,
   input  logic                    mac_valid_out,
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic [15:0]             rsp_data,
   output logic [ID_W-1:0]         rsp_id,
   output logic                    err
);
   localparam int CNT_W = $clog2(FIFO_DEPTH + MAC_LAT + 1);
   localparam int FC_W  = $clog2(FIFO_DEPTH) + 1;
   localparam int LAST  = MAC_LAT - 1;

   logic [ID_W-1:0]    rr_ptr;
   logic [ID_W-1:0]    gnt_idx;
   logic               found;
   logic               credit_ok;
   logic               issue;
   logic [MAC_LAT-1:0] tag_v;
   logic [ID_W-1:0]    tag_id [MAC_LAT];
   logic [CNT_W-1:0]   inflight;
   logic [FC_W-1:0]    fifo_count;
   logic               fifo_full;
   logic               fifo_empty;
   logic               push;
   logic               pop;
   logic [ID_W+15:0]   fifo_head;

   always_comb begin
      inflight = '0;
      for (int s = 0; s < MAC_LAT; s++) inflight = inflight + CNT_W'(tag_v[s]);
   end

   assign credit_ok = (CNT_W'(fifo_count) + inflight) < CNT_W'(FIFO_DEPTH);

   always_comb begin
      found   = 1'b0;
      gnt_idx = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         if (!found && req_valid[ID_W'((int'(rr_ptr) + k) % NUM_REQ)]) begin
            found   = 1'b1;
            gnt_idx = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
         end
      end
   end

   // Gating with reset keeps req_ready/mac_valid low while the block is held in reset.
   assign issue        = found && credit_ok && reset;
   assign req_ready    = issue ? (NUM_REQ'(1) << gnt_idx) : '0;
   assign mac_valid    = issue;
   assign mac_ready_in = 1'b1;

   always_comb begin
      mac_a = '0;
      mac_b = '0;
      mac_c = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (issue && gnt_idx == ID_W'(i)) begin
            mac_a = req_a[8*i +: 8];
            mac_b = req_b[8*i +: 8];
            mac_c = req_c[16*i +: 16];
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rr_ptr <= ID_W'(NUM_REQ - 1);
         tag_v  <= '0;
         for (int s = 0; s < MAC_LAT; s++) tag_id[s] <= '0;
      end else begin
         if (issue) rr_ptr <= gnt_idx;
         tag_v     <= {tag_v[MAC_LAT-2:0], issue};
         tag_id[0] <= gnt_idx;
         for (int s = 1; s < MAC_LAT; s++) tag_id[s] <= tag_id[s-1];
      end
   end

   assign push = tag_v[LAST] && mac_valid_out;
   assign pop  = rsp_valid && rsp_ready;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         err <= 1'b0;
      end else if ((tag_v[LAST] != mac_valid_out) || (push && fifo_full && !pop)) begin
         err <= 1'b1;
      end
   end

   mac_rsp_fifo #(.DEPTH(FIFO_DEPTH), .W(ID_W + 16)) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push),
      .push_data ({tag_id[LAST], mac_result}),
      .pop       (pop),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count),
      .head      (fifo_head)
   );

   assign rsp_valid = !fifo_empty;
   assign rsp_data  = rsp_valid ? fifo_head[15:0] : '0;
   assign rsp_id    = rsp_valid ? fifo_head[ID_W+15:16] : '0;
endmodule

// File: tb/tb_mac_rr_scheduler.sv
// tb/tb_mac_rr_scheduler.sv - randomized self-checking bench for mac_rr_scheduler

module tb_mac_rr_scheduler;
   localparam int N     = 4;
   localparam int DEPTH = 8;
   localparam int LAT   = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [3:0]  req_valid = '0;
   logic [3:0]  req_ready;
   logic [31:0] req_a = '0;
   logic [31:0] req_b = '0;
   logic [63:0] req_c = '0;
   logic [7:0]  mac_a;
   logic [7:0]  mac_b;
   logic [15:0] mac_c;
   logic        mac_valid;
   logic        mac_ready_in;
   logic [15:0] mac_result;
   logic        mac_valid_out;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [15:0] rsp_data;
   logic [1:0]  rsp_id;
   logic        err;
   logic        mac_force = 1'b0;

   always #5 clk = ~clk;

   mac_rr_scheduler #(.NUM_REQ(N), .FIFO_DEPTH(DEPTH), .MAC_LAT(LAT)) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .req_c(req_c),
      .mac_a(mac_a), .mac_b(mac_b), .mac_c(mac_c), .mac_valid(mac_valid),
      .mac_ready_in(mac_ready_in), .mac_result(mac_result), .mac_valid_out(mac_valid_out),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .rsp_id(rsp_id), .err(err)
   );

   // Stand-in for the pipelined MAC: LAT stages including the input capture register.
   logic [LAT-1:0] mp_v;
   logic [15:0]    mp_r [LAT];
   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         mp_v <= '0;
         for (int i = 0; i < LAT; i++) mp_r[i] <= '0;
      end else begin
         mp_v    <= {mp_v[LAT-2:0], mac_valid};
         mp_r[0] <= mac_a * mac_b + mac_c;
         for (int i = 1; i < LAT; i++) mp_r[i] <= mp_r[i-1];
      end
   end
   assign mac_result    = mp_r[LAT-1];
   assign mac_valid_out = mp_v[LAT-1] | mac_force;

   // Reference model: accepted-but-unpopped count is the credit, queue holds expected responses.
   typedef struct { int id; int data; int vis; } rsp_t;
   rsp_t       exp_q[$];
   int         m_ptr = N - 1;
   int         m_out = 0;
   int         cyc = 0;
   int         passed = 0;
   int         total = 0;
   logic [3:0] exp_gnt;
   logic       exp_rv;
   logic [17:0] exp_head;

   task automatic eval_model();
      int idx;
      #1;
      exp_gnt = '0;
      if (reset && m_out < DEPTH) begin
         for (int k = 1; k <= N; k++) begin
            idx = (m_ptr + k) % N;
            if (exp_gnt == 0 && req_valid[idx]) exp_gnt = 4'(1 << idx);
         end
      end
      exp_rv   = exp_q.size() > 0 && exp_q[0].vis <= cyc;
      exp_head = exp_rv ? {2'(exp_q[0].id), 16'(exp_q[0].data)} : '0;
   endtask

   task automatic advance();
      rsp_t e;
      int   a, b, c;
      if (exp_gnt != 0) begin
         for (int k = 0; k < N; k++) if (exp_gnt[k]) e.id = k;
         a = int'(req_a[8*e.id +: 8]);
         b = int'(req_b[8*e.id +: 8]);
         c = int'(req_c[16*e.id +: 16]);
         e.data = (a * b + c) % 65536;
         e.vis  = cyc + 1 + LAT;
         exp_q.push_back(e);
         m_ptr = e.id;
         m_out++;
      end
      if (exp_rv && rsp_ready) begin
         void'(exp_q.pop_front());
         m_out--;
      end
      @(posedge clk);
      cyc++;
      @(negedge clk);
   endtask

   task automatic rand_ops();
      req_a = $urandom;
      req_b = $urandom;
      req_c = {$urandom, $urandom};
   endtask

   task automatic do_reset();
      reset = 1'b0;
      req_valid = '0;
      rsp_ready = 1'b0;
      mac_force = 1'b0;
      exp_q.delete();
      m_ptr = N - 1;
      m_out = 0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      req_valid = 4'hF;
      rsp_ready = 1'b1;
      rand_ops();
      repeat (3) @(negedge clk);
      total++;
      if (req_ready !== 4'b0 || mac_valid !== 1'b0) $display("FAIL reset_issue req_ready=%b mac_valid=%b required 0000/0", req_ready, mac_valid);
      else passed++;
      total++;
      if ({mac_a, mac_b, mac_c} !== 32'h0) $display("FAIL reset_mac_ops got=%h required 0", {mac_a, mac_b, mac_c});
      else passed++;
      total++;
      if (rsp_valid !== 1'b0 || rsp_data !== 16'h0 || rsp_id !== 2'b0 || err !== 1'b0)
         $display("FAIL reset_rsp rsp_valid=%b rsp_data=%h rsp_id=%0d err=%b required all 0", rsp_valid, rsp_data, rsp_id, err);
      else passed++;
      exp_q.delete();
      m_ptr = N - 1;
      m_out = 0;
      reset = 1'b1;
      eval_model();
      total++;
      if (req_ready !== exp_gnt || req_ready !== 4'b0001) $display("FAIL reset_first_grant got=%b required 0001", req_ready);
      else passed++;
      advance();
   endtask

   task automatic test_single_op();
      int t_id[3]  = '{1, 3, 0};
      int t_a[3]   = '{3, 255, 0};
      int t_b[3]   = '{5, 255, 17};
      int t_c[3]   = '{7, 65535, 9};
      int t_exp[3] = '{22, 16'hFE00, 9};
      int seen;
      logic [15:0] got_d;
      logic [1:0]  got_id;
      do_reset();
      for (int j = 0; j < 3; j++) begin
         req_a = '0; req_b = '0; req_c = '0; req_valid = '0;
         req_a[8*t_id[j] +: 8]   = 8'(t_a[j]);
         req_b[8*t_id[j] +: 8]   = 8'(t_b[j]);
         req_c[16*t_id[j] +: 16] = 16'(t_c[j]);
         req_valid[t_id[j]] = 1'b1;
         rsp_ready = 1'b1;
         seen = -1; got_d = '0; got_id = '0;
         for (int t = 0; t < 10; t++) begin
            eval_model();
            total++;
            if (req_ready !== exp_gnt) $display("FAIL single_grant op=%0d t=%0d got=%b required %b", j, t, req_ready, exp_gnt);
            else passed++;
            total++;
            if (rsp_valid !== exp_rv || (exp_rv && {rsp_id, rsp_data} !== exp_head))
               $display("FAIL single_rsp op=%0d t=%0d got=%b/%h required %b/%h", j, t, rsp_valid, {rsp_id, rsp_data}, exp_rv, exp_head);
            else passed++;
            if (t == 0) begin
               total++;
               if (mac_valid !== 1'b1 || mac_a !== 8'(t_a[j]) || mac_b !== 8'(t_b[j]) || mac_c !== 16'(t_c[j]))
                  $display("FAIL single_mac_ops op=%0d got=%b %h %h %h required 1 %h %h %h", j, mac_valid, mac_a, mac_b, mac_c, 8'(t_a[j]), 8'(t_b[j]), 16'(t_c[j]));
               else passed++;
            end
            if (rsp_valid && seen < 0) begin seen = t; got_d = rsp_data; got_id = rsp_id; end
            advance();
            if (t == 0) req_valid = '0;
         end
         total++;
         if (seen != LAT + 1 || got_d !== 16'(t_exp[j]) || got_id !== 2'(t_id[j]))
            $display("FAIL single_result op=%0d got t=%0d data=%h id=%0d required t=%0d data=%h id=%0d", j, seen, got_d, got_id, LAT + 1, 16'(t_exp[j]), t_id[j]);
         else passed++;
      end
   endtask

   task automatic test_fairness();
      int n_iss, n_pop, first_pop;
      int bad_iss, bad_pop;
      do_reset();
      rsp_ready = 1'b1;
      n_iss = 0; n_pop = 0; first_pop = -1; bad_iss = 0; bad_pop = 0;
      for (int t = 0; t < 20; t++) begin
         req_valid = (t < 8) ? 4'hF : 4'h0;
         rand_ops();
         eval_model();
         total++;
         if (req_ready !== exp_gnt) $display("FAIL fair_grant t=%0d got=%b required %b", t, req_ready, exp_gnt);
         else passed++;
         total++;
         if (rsp_valid !== exp_rv || (exp_rv && {rsp_id, rsp_data} !== exp_head))
            $display("FAIL fair_rsp t=%0d got=%b/%h required %b/%h", t, rsp_valid, {rsp_id, rsp_data}, exp_rv, exp_head);
         else passed++;
         if (req_ready != 0) begin
            if (req_ready !== 4'(1 << (n_iss % N)) || t != n_iss) bad_iss++;
            n_iss++;
         end
         if (rsp_valid) begin
            if (first_pop < 0) first_pop = t;
            if (rsp_id !== 2'(n_pop % N) || t != first_pop + n_pop) bad_pop++;
            n_pop++;
         end
         advance();
      end
      total++;
      if (n_iss != 8 || bad_iss != 0) $display("FAIL fair_rotation issues=%0d out_of_order=%0d required 8/0", n_iss, bad_iss);
      else passed++;
      total++;
      if (n_pop != 8 || bad_pop != 0) $display("FAIL fair_rsp_order pops=%0d out_of_order=%0d required 8/0", n_pop, bad_pop);
      else passed++;
   endtask

   task automatic test_back_pressure();
      int accepts;
      do_reset();
      rsp_ready = 1'b0;
      req_valid = 4'hF;
      accepts = 0;
      for (int t = 0; t < 20; t++) begin
         rand_ops();
         eval_model();
         total++;
         if (req_ready !== exp_gnt) $display("FAIL bp_stall_grant t=%0d got=%b required %b", t, req_ready, exp_gnt);
         else passed++;
         if (req_ready != 0) accepts++;
         advance();
      end
      total++;
      if (accepts != DEPTH) $display("FAIL bp_accept_count got=%0d required %0d", accepts, DEPTH);
      else passed++;
      for (int t = 0; t < 80; t++) begin
         rsp_ready = (t < 40) ? 1'b1 : 1'b0;
         if (t >= 40) rsp_ready = 1'b1;
         req_valid = (t < 40) ? 4'($urandom) : 4'h0;
         rand_ops();
         eval_model();
         total++;
         if (req_ready !== exp_gnt) $display("FAIL bp_drain_grant t=%0d got=%b required %b", t, req_ready, exp_gnt);
         else passed++;
         total++;
         if (rsp_valid !== exp_rv || (exp_rv && {rsp_id, rsp_data} !== exp_head))
            $display("FAIL bp_drain_rsp t=%0d got=%b/%h required %b/%h", t, rsp_valid, {rsp_id, rsp_data}, exp_rv, exp_head);
         else passed++;
         advance();
      end
      total++;
      if (exp_q.size() != 0 || rsp_valid !== 1'b0 || err !== 1'b0)
         $display("FAIL bp_final left=%0d rsp_valid=%b err=%b required 0/0/0", exp_q.size(), rsp_valid, err);
      else passed++;
   endtask

   task automatic test_random();
      do_reset();
      for (int t = 0; t < 400; t++) begin
         req_valid = (t < 360) ? 4'($urandom) : 4'h0;
         rsp_ready = (t < 360) ? ($urandom_range(0, 3) != 0) : 1'b1;
         rand_ops();
         eval_model();
         total++;
         if (req_ready !== exp_gnt) $display("FAIL rand_grant t=%0d got=%b required %b", t, req_ready, exp_gnt);
         else passed++;
         total++;
         if (rsp_valid !== exp_rv || (exp_rv && {rsp_id, rsp_data} !== exp_head))
            $display("FAIL rand_rsp t=%0d got=%b/%h required %b/%h", t, rsp_valid, {rsp_id, rsp_data}, exp_rv, exp_head);
         else passed++;
         advance();
      end
      total++;
      if (exp_q.size() != 0 || err !== 1'b0) $display("FAIL rand_final left=%0d err=%b required 0/0", exp_q.size(), err);
      else passed++;
   endtask

   task automatic test_misalign();
      do_reset();
      rsp_ready = 1'b0;
      eval_model();
      total++;
      if (err !== 1'b0) $display("FAIL mis_pre err=%b required 0", err);
      else passed++;
      mac_force = 1'b1;
      advance();
      mac_force = 1'b0;
      eval_model();
      total++;
      if (err !== 1'b1 || rsp_valid !== 1'b0) $display("FAIL mis_set err=%b rsp_valid=%b required 1/0", err, rsp_valid);
      else passed++;
      repeat (6) advance();
      total++;
      if (err !== 1'b1 || rsp_valid !== 1'b0) $display("FAIL mis_sticky err=%b rsp_valid=%b required 1/0", err, rsp_valid);
      else passed++;
   endtask

   initial begin
      test_reset();
      test_single_op();
      test_fairness();
      test_back_pressure();
      test_random();
      test_misalign();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
